// File: rtl/fpu_operand_sequencer.sv
// fpu_operand_sequencer: queues operand pairs, holds each one on the FPU inputs for a fixed window, returns tagged results
module fpu_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int TAG_W = 4
) (
  input  logic                       clock_100Khz,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_op_a,
  input  logic [31:0]                in_op_b,
  output logic [31:0]                op_a_out,
  output logic [31:0]                op_b_out,
  input  logic [31:0]                fpu_data_in,
  input  logic [3:0]                 fpu_status_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [3:0]                 res_status,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, RESULT} state_t;
  state_t state, state_next;
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TAG_W-1:0] tag_ctr, issue_tag;
  logic [HW-1:0] hold_ctr;
  logic [CW-1:0] count_next;
  logic push, pop, hold_done;
  assign push = in_valid && in_ready;
  assign pop = state == IDLE && fifo_count != '0;
  assign hold_done = hold_ctr == HW'(HOLD_CYCLES - 1);
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clock_100Khz) state <= reset ? IDLE : state_next;
  // issue when work is queued, capture after the hold window, wait for the consumer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = pop ? ISSUE : IDLE;
      ISSUE:   state_next = hold_done ? RESULT : ISSUE;
      default: state_next = res_ready ? IDLE : RESULT;
    endcase
  end
  // FIFO storage needs no reset; pointers and count decide what is live
  always_ff @(posedge clock_100Khz) begin
    if (push) begin
      mem_a[wr_ptr] <= in_op_a;
      mem_b[wr_ptr] <= in_op_b;
      mem_tag[wr_ptr] <= tag_ctr;
    end
  end
  // FIFO pointers, occupancy, registered ready and sequence tag
  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      in_ready <= 1'b1;
      tag_ctr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        tag_ctr <= tag_ctr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      in_ready <= count_next != CW'(DEPTH);
    end
  end
  // operand drive, hold counting and result capture
  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      op_a_out <= '0;
      op_b_out <= '0;
      issue_tag <= '0;
      hold_ctr <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_status <= 4'd2;
      res_tag <= '0;
    end else begin
      if (pop) begin
        op_a_out <= mem_a[rd_ptr];
        op_b_out <= mem_b[rd_ptr];
        issue_tag <= mem_tag[rd_ptr];
        hold_ctr <= '0;
      end else if (state == ISSUE && !hold_done) hold_ctr <= hold_ctr + 1'b1;
      if (state == ISSUE && hold_done) begin
        res_valid <= 1'b1;
        res_data <= fpu_data_in;
        res_status <= fpu_status_in;
        res_tag <= issue_tag;
      end else if (res_valid && res_ready) res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// tb_fpu_operand_sequencer: directed and random checks of the sequencer against a transaction-level model
module tb_fpu_operand_sequencer;
  localparam int DEPTH = 4;
  localparam int HOLD = 8;
  localparam int TW = 4;
  localparam int CW = 3;
  logic clock_100Khz = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic [35:0] noise = '0;
  logic in_ready, res_valid, busy;
  logic [31:0] op_a_out, op_b_out, fpu_data_in, res_data;
  logic [3:0] fpu_status_in, res_status;
  logic [TW-1:0] res_tag;
  logic [CW-1:0] fifo_count;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clock_100Khz = ~clock_100Khz;
  // FPU stand-in: result depends only on the held operands, plus a per-cycle disturbance
  function automatic logic [35:0] fpu(input logic [31:0] a, input logic [31:0] b);
    return {a[3:0] ^ b[3:0] ^ 4'd2, a + (b >> 9)};
  endfunction
  assign {fpu_status_in, fpu_data_in} = fpu(op_a_out, op_b_out) ^ noise;
  fpu_operand_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TAG_W(TW)) dut (
    .clock_100Khz(clock_100Khz), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .op_a_out(op_a_out), .op_b_out(op_b_out),
    .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_status(res_status), .res_tag(res_tag),
    .busy(busy), .fifo_count(fifo_count)
  );
  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  // model: queue of waiting pairs, one pair in flight, one result slot
  logic [67:0] mq[$];
  logic [TW-1:0] got[$];
  logic started = 1'b0;
  logic m_inf, m_rv;
  logic [31:0] m_a, m_b, m_rd;
  logic [3:0] m_rs;
  logic [TW-1:0] m_tag, m_it, m_rt;
  int cyc = 0;
  int m_icyc = 0;
  always @(posedge clock_100Khz) begin : model
    bit acc;
    int sz0;
    logic [67:0] e;
    logic [35:0] r;
    started = 1'b1;
    if (res_valid && res_ready && !reset) got.push_back(res_tag);
    if (reset) begin
      mq.delete();
      m_inf = 0; m_rv = 0; m_tag = '0; m_it = '0;
      m_a = '0; m_b = '0; m_rd = '0; m_rs = 4'd2; m_rt = '0;
    end else begin
      sz0 = mq.size();
      acc = in_valid && sz0 < DEPTH;
      if (m_rv) begin
        if (res_ready) m_rv = 0;
      end else if (m_inf) begin
        if (cyc - m_icyc == HOLD) begin
          r = fpu(m_a, m_b) ^ noise;
          m_rd = r[31:0]; m_rs = r[35:32]; m_rt = m_it;
          m_rv = 1; m_inf = 0;
        end
      end else if (sz0 > 0) begin
        e = mq.pop_front();
        m_a = e[67:36]; m_b = e[35:4]; m_it = e[3:0];
        m_inf = 1; m_icyc = cyc;
      end
      if (acc) begin
        mq.push_back({in_op_a, in_op_b, m_tag});
        m_tag = m_tag + 1'b1;
      end
    end
    cyc++;
  end
  // every-cycle comparison against the model
  always @(negedge clock_100Khz) begin
    if (started) begin
      chk("in_ready", 36'(in_ready), 36'(mq.size() < DEPTH));
      chk("fifo_count", 36'(fifo_count), 36'(mq.size()));
      chk("busy", 36'(busy), 36'(m_inf || m_rv));
      chk("res_valid", 36'(res_valid), 36'(m_rv));
      chk("op_a_out", 36'(op_a_out), 36'(m_a));
      chk("op_b_out", 36'(op_b_out), 36'(m_b));
      chk("res_data", 36'(res_data), 36'(m_rd));
      chk("res_status", 36'(res_status), 36'(m_rs));
      chk("res_tag", 36'(res_tag), 36'(m_rt));
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clock_100Khz);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    got.delete();
  endtask
  task automatic wait_got(input int n, input int limit);
    for (int i = 0; i < limit && got.size() < n; i++) step(1);
    chk("result count", 36'(got.size()), 36'(n));
  endtask
  initial begin
    int accepted;
    step(2);
    reset = 1'b0;
    chk("rst in_ready", 36'(in_ready), 36'(1));
    chk("rst res_valid", 36'(res_valid), 36'(0));
    chk("rst op_a_out", 36'(op_a_out), 36'(0));
    chk("rst res_status", 36'(res_status), 36'(2));
    chk("rst fifo_count", 36'(fifo_count), 36'(0));
    chk("rst busy", 36'(busy), 36'(0));
    // single operation with literal expectations
    res_ready = 1'b1;
    in_valid = 1'b1; in_op_a = 32'h4000_0000; in_op_b = 32'h4000_0000;
    step(1);
    in_valid = 1'b0;
    step(1);
    chk("single op_a_out", 36'(op_a_out), 36'(32'h4000_0000));
    step(7);
    chk("single early valid", 36'(res_valid), 36'(0));
    step(1);
    chk("single res_valid", 36'(res_valid), 36'(1));
    chk("single res_data", 36'(res_data), 36'(32'h4020_0000));
    chk("single res_status", 36'(res_status), 36'(2));
    chk("single res_tag", 36'(res_tag), 36'(0));
    step(3);
    // backpressure and full FIFO
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_op_a = 32'h100 + i; in_op_b = 32'h200 + i;
      step(1);
    end
    in_valid = 1'b0;
    chk("full fifo_count", 36'(fifo_count), 36'(4));
    chk("full in_ready", 36'(in_ready), 36'(0));
    step(5);
    res_ready = 1'b1;
    wait_got(5, 200);
    step(15);
    chk("no extra results", 36'(got.size()), 36'(5));
    in_valid = 1'b1; in_op_a = 32'h3f80_0000; in_op_b = 32'h1;
    step(1);
    in_valid = 1'b0;
    wait_got(6, 50);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("bp tag %0d", i), 36'(got[i]), 36'(i));
    // tag wrap with operands changing every cycle
    do_reset();
    accepted = 0;
    for (int i = 0; i < 2000 && accepted < 20; i++) begin
      in_valid = 1'b1; in_op_a = $urandom; in_op_b = $urandom;
      @(posedge clock_100Khz);
      if (in_ready) accepted++;
      @(negedge clock_100Khz);
    end
    in_valid = 1'b0;
    wait_got(20, 400);
    for (int i = 0; i < 20 && i < got.size(); i++) chk($sformatf("wrap tag %0d", i), 36'(got[i]), 36'(i % 16));
    // reset in the middle of a hold window
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op_a = 32'h500 + i; in_op_b = 32'h600 + i;
      step(1);
    end
    in_valid = 1'b0;
    step(2);
    chk("pre-reset fifo_count", 36'(fifo_count), 36'(2));
    reset = 1'b1;
    step(1);
    chk("midrst fifo_count", 36'(fifo_count), 36'(0));
    chk("midrst res_valid", 36'(res_valid), 36'(0));
    reset = 1'b0;
    got.delete();
    step(30);
    chk("no stale result", 36'(got.size()), 36'(0));
    in_valid = 1'b1; in_op_a = 32'h777; in_op_b = 32'h888;
    step(1);
    in_valid = 1'b0;
    wait_got(1, 50);
    if (got.size() > 0) chk("post-reset tag", 36'(got[0]), 36'(0));
    // randomized traffic with a disturbed FPU result
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 399) == 0;
      in_valid = $urandom_range(0, 1) == 1;
      res_ready = $urandom_range(0, 3) != 0;
      in_op_a = $urandom; in_op_b = $urandom;
      noise = {4'($urandom), 32'($urandom)};
      step(1);
    end
    reset = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    step(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_operand_sequencer.md
Name: fpu_operand_sequencer

Overview:
- Upstream/downstream companion to the FPU core, which has no handshake: it free-runs and samples Op_A_in/Op_B_in on its own internal schedule.
- Accepts operand pairs over a valid/ready interface into a small FIFO and drives one pair at a time, held stable, on the FPU operand inputs.
- Waits a fixed hold window, then captures the FPU's data_out/status_out and presents the result, tagged, over a valid/ready output interface.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 64, cycles each pair is held on the FPU inputs before capture; minimum 2. The default covers two worst-case FPU iterations, so the captured result always belongs to the held pair.
- TAG_W, 4, width of the sequence tag.

Ports:
- clock_100Khz  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full, registered.
- in_op_a  in  32  operand A, FPU format {sign, exp[9:0], mant[20:0]}.
- in_op_b  in  32  operand B, same format.
- op_a_out  out  32  to FPU Op_A_in.
- op_b_out  out  32  to FPU Op_B_in.
- fpu_data_in  in  32  from FPU data_out.
- fpu_status_in  in  4  from FPU status_out (OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  captured result.
- res_status  out  4  captured status.
- res_tag  out  TAG_W  tag of the pair that produced the result.
- busy  out  1  high in ISSUE or RESULT.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (on a sampled clock edge): FIFO empty, fifo_count=0, in_ready=1, op_a_out=op_b_out=0, res_valid=0, res_data=0, res_status=EXACT (2), res_tag=0, tag counter=0, hold counter=0, state IDLE, busy=0.
- Reset asserted mid-operation abandons the in-flight pair and all queued pairs; no result is emitted for them.
- Push: on in_valid && in_ready, {in_op_a, in_op_b, tag_ctr} is written at the tail and tag_ctr increments, wrapping 2^TAG_W-1 -> 0.
- in_valid while full is ignored: no write, no tag increment. There is no bypass, so a push into a full FIFO is never accepted, even in a pop cycle.
- Pointer wrap at DEPTH is a plain modulo.
- FSM states: IDLE, ISSUE, RESULT.
- IDLE, fifo_count>0: pop the head, load op_a_out/op_b_out and the issue tag, clear the hold counter, go to ISSUE.
- IDLE, FIFO empty: stay in IDLE; op_a_out/op_b_out keep their last values.
- ISSUE: op_a_out/op_b_out stay constant and the hold counter increments each cycle. On the cycle the counter equals HOLD_CYCLES-1: register fpu_data_in -> res_data, fpu_status_in -> res_status, issue tag -> res_tag; set res_valid=1; go to RESULT. ISSUE therefore lasts exactly HOLD_CYCLES cycles.
- RESULT: res_* are held stable while res_valid=1. On res_valid && res_ready: clear res_valid, go to IDLE. There is one IDLE bubble before the next issue.
- Latency: a push accepted at edge t gives a pop at edge t+1 (if the FSM is IDLE) and res_valid=1 after edge t+1+HOLD_CYCLES. Steady-state throughput is one pair per HOLD_CYCLES+2 cycles, with res_ready held high.
- Pushes are accepted in every state while not full; push and pop may occur in the same cycle, leaving fifo_count unchanged.
- fifo_count and in_ready reflect registered state only.
- The block does not interpret or modify operand or result bits.

Test Plan:
- Reset values: assert reset 2 cycles, then release -> in_ready=1, res_valid=0, op_a_out=0, res_status=2, fifo_count=0, busy=0.
- Single op (HOLD_CYCLES=8, FPU stub): push A=0x40000000, B=0x40000000 at edge t; stub drives 0x40200000, status 2 -> op_a_out=0x40000000 from edge t+1; res_valid rises after edge t+9 with res_data=0x40200000, res_status=2, res_tag=0.
- Backpressure and full (DEPTH=4): hold res_ready=0 and push 6 pairs back-to-back -> 1 issued, 4 queued, in_ready=0 and fifo_count=4. The 6th pair is dropped with no tag increment. Release res_ready -> results return in order with tags 0,1,2,3,4.
- Tag wrap: push 20 pairs (TAG_W=4) -> res_tag sequence 0..15,0..3; pairs are never reordered.
- Hold stability: during ISSUE, change in_op_a every cycle while pushing -> op_a_out stays constant for exactly HOLD_CYCLES cycles; the captured status reflects the stub value on the final ISSUE cycle (e.g. 0 = OVERFLOW).
- Reset mid-operation: assert reset at hold counter 3 with 2 pairs queued -> next edge shows FIFO empty and res_valid=0; no stale result afterwards; the next push gets res_tag=0.
